// File: rtl/fpmul_pkg.sv
// Shared definitions for the FP multiplier sharing arbiter: defaults, FSM
// encoding and an index-width helper.
package fpmul_pkg;

  localparam int N_REQ_DEFAULT = 4;
  localparam int TMO_DEFAULT   = 15;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    CAPT  = 2'd2,
    RELS  = 2'd3
  } arb_state_e;

  // Index width that stays legal for a single requester.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin priority select: first requester at or above Ptr, wrapping.
module rr_pick
  import fpmul_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEFAULT,
  parameter int IW    = idx_width(N_REQ)
) (
  input  logic [N_REQ-1:0] Req,
  input  logic [IW-1:0]    Ptr,
  output logic [N_REQ-1:0] Grant,
  output logic [IW-1:0]    Idx,
  output logic             Valid
);

  always_comb begin
    int j;
    logic [IW-1:0] jj;
    Grant = '0;
    Idx   = '0;
    Valid = 1'b0;
    j     = 0;
    jj    = '0;
    for (int k = 0; k < N_REQ; k++) begin
      j = int'(Ptr) + k;
      if (j >= N_REQ) j = j - N_REQ;
      jj = IW'(j);
      if (!Valid && Req[jj]) begin
        Valid     = 1'b1;
        Grant[jj] = 1'b1;
        Idx       = jj;
      end
    end
  end

endmodule

// File: rtl/fpmul_share_arb.sv
// Arbitrates N_REQ requesters onto one external FP multiplier, with a
// watchdog that aborts a multiply that never reports Mul_Done.
module fpmul_share_arb
  import fpmul_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEFAULT,
  parameter int TMO   = TMO_DEFAULT
) (
  input  logic               Clk,
  input  logic               Rst_n,
  input  logic [N_REQ-1:0]   Req,
  input  logic [32*N_REQ-1:0] ReqA,
  input  logic [32*N_REQ-1:0] ReqB,
  output logic [N_REQ-1:0]   Ack,
  output logic [31:0]        RspP,
  output logic               RspOvf,
  output logic               RspUnf,
  output logic               RspErr,
  output logic               Busy,
  output logic               Mul_St,
  output logic [31:0]        Mul_A,
  output logic [31:0]        Mul_B,
  input  logic               Mul_Done,
  input  logic               Mul_Ovf,
  input  logic               Mul_Unf,
  input  logic [31:0]        Mul_P,
  output logic [1:0]         Dbg_State
);

  // Handshake: Req[i] is a level held with stable operands until Ack[i];
  // Ack[i] is a one-cycle pulse carrying Rsp*. A requester that drops Req
  // early still receives its result.

  localparam int IW = idx_width(N_REQ);
  localparam int CW = $clog2(TMO + 1);
  localparam logic [CW-1:0] TMO_LAST = CW'(TMO - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(N_REQ - 1);

  arb_state_e       state;
  logic [IW-1:0]    ptr;
  logic [IW-1:0]    g_idx;
  logic [N_REQ-1:0] g_oh;
  logic [CW-1:0]    cnt;

  logic [N_REQ-1:0] pick_oh;
  logic [IW-1:0]    pick_idx;
  logic             pick_vld;
  logic [IW-1:0]    next_ptr;

  rr_pick #(.N_REQ(N_REQ), .IW(IW)) u_pick (
    .Req   (Req),
    .Ptr   (ptr),
    .Grant (pick_oh),
    .Idx   (pick_idx),
    .Valid (pick_vld)
  );

  assign next_ptr  = (g_idx == IDX_LAST) ? '0 : g_idx + 1'b1;
  assign Dbg_State = state;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state  <= IDLE;
      ptr    <= '0;
      g_idx  <= '0;
      g_oh   <= '0;
      cnt    <= '0;
      Ack    <= '0;
      RspP   <= '0;
      RspOvf <= 1'b0;
      RspUnf <= 1'b0;
      RspErr <= 1'b0;
      Busy   <= 1'b0;
      Mul_St <= 1'b0;
      Mul_A  <= '0;
      Mul_B  <= '0;
    end else begin
      case (state)
        IDLE: begin
          Ack  <= '0;
          cnt  <= '0;
          Busy <= pick_vld;
          if (pick_vld) begin
            g_idx  <= pick_idx;
            g_oh   <= pick_oh;
            Mul_A  <= ReqA[int'(pick_idx)*32 +: 32];
            Mul_B  <= ReqB[int'(pick_idx)*32 +: 32];
            Mul_St <= 1'b1;
            state  <= ISSUE;
          end
        end
        ISSUE: begin
          // Result is captured on the edge that enters CAPT so that Ack and
          // Rsp* are visible for the whole CAPT cycle.
          if (Mul_Done || cnt == TMO_LAST) begin
            state  <= CAPT;
            cnt    <= '0;
            Mul_St <= 1'b0;
            Ack    <= g_oh;
            ptr    <= next_ptr;
            if (Mul_Done) begin
              RspP   <= Mul_P;
              RspOvf <= Mul_Ovf;
              RspUnf <= Mul_Unf;
              RspErr <= 1'b0;
            end else begin
              RspP   <= '0;
              RspOvf <= 1'b0;
              RspUnf <= 1'b0;
              RspErr <= 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        CAPT: begin
          Ack   <= '0;
          cnt   <= '0;
          state <= RELS;
        end
        RELS: begin
          // Busy bridges the single IDLE hop when more work is already waiting.
          if (!Mul_Done || cnt == TMO_LAST) begin
            state <= IDLE;
            cnt   <= '0;
            Busy  <= |Req;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fpmul_share_arb.sv
// Bench for fpmul_share_arb: behavioural FP multiplier responder plus a
// round-robin reference model feeding an expected-response queue.
module tb_fpmul_share_arb;
  import fpmul_pkg::*;

  localparam int N   = 4;
  localparam int TMO = 15;
  localparam int W   = 37;  // {idx[1:0], err, unf, ovf, p[31:0]}

  logic             Clk = 1'b0;
  logic             Rst_n = 1'b0;
  logic [N-1:0]     Req = '0;
  logic [32*N-1:0]  ReqA = '0;
  logic [32*N-1:0]  ReqB = '0;
  logic [N-1:0]     Ack;
  logic [31:0]      RspP;
  logic             RspOvf, RspUnf, RspErr, Busy, Mul_St;
  logic [31:0]      Mul_A, Mul_B;
  logic             Mul_Done = 1'b0;
  logic             Mul_Ovf = 1'b0;
  logic             Mul_Unf = 1'b0;
  logic [31:0]      Mul_P = '0;
  logic [1:0]       Dbg_State;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int mul_lat = 0;
  bit mul_hang = 1'b0;
  int mcnt = 0;
  int done_cyc = -1;
  int ack_cyc = -1;
  int bad_oh = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] obs_q[$];

  fpmul_share_arb #(.N_REQ(N), .TMO(TMO)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .Req(Req), .ReqA(ReqA), .ReqB(ReqB),
    .Ack(Ack), .RspP(RspP), .RspOvf(RspOvf), .RspUnf(RspUnf), .RspErr(RspErr),
    .Busy(Busy), .Mul_St(Mul_St), .Mul_A(Mul_A), .Mul_B(Mul_B),
    .Mul_Done(Mul_Done), .Mul_Ovf(Mul_Ovf), .Mul_Unf(Mul_Unf), .Mul_P(Mul_P),
    .Dbg_State(Dbg_State)
  );

  // ---------------- clock / reset ----------------
  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc++;

  initial begin
    #400000;
    $display("FAIL global_timeout got=running want=finished");
    $fatal(1);
  end

  // ---------------- reference arithmetic ----------------
  // Truncating single-precision multiply, returns {ovf, unf, p}.
  function automatic logic [33:0] fp_mul(input logic [31:0] a, input logic [31:0] b);
    logic s;
    int e;
    logic [47:0] pr;
    logic [22:0] m;
    s = a[31] ^ b[31];
    if (a[30:23] == 8'd0 || b[30:23] == 8'd0) return {2'b00, s, 31'd0};
    pr = {1'b1, a[22:0]} * {1'b1, b[22:0]};
    e = int'(a[30:23]) + int'(b[30:23]) - 127;
    if (pr[47]) begin
      m = pr[46:24];
      e++;
    end else begin
      m = pr[45:23];
    end
    if (e >= 255) return {2'b10, s, 8'hFF, 23'd0};
    if (e <= 0) return {2'b01, s, 31'd0};
    return {2'b00, s, e[7:0], m};
  endfunction

  function automatic logic [W-1:0] mk_exp(input int idx, input logic [33:0] r);
    return {2'(idx), 1'b0, r[32], r[33], r[31:0]};
  endfunction

  function automatic int rr_next(input logic [N-1:0] pend, input int ptr);
    for (int k = 0; k < N; k++) begin
      if (pend[(ptr + k) % N]) return (ptr + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [31:0] rand_op();
    return {1'($urandom_range(0, 1)), 8'($urandom_range(64, 190)), 23'($urandom)};
  endfunction

  // ---------------- multiplier responder ----------------
  always @(negedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      Mul_Done = 1'b0; Mul_P = '0; Mul_Ovf = 1'b0; Mul_Unf = 1'b0; mcnt = 0;
    end else if (!Mul_St) begin
      Mul_Done = 1'b0; mcnt = 0;
    end else if (!Mul_Done && !mul_hang) begin
      if (mcnt >= mul_lat) begin
        {Mul_Ovf, Mul_Unf, Mul_P} = fp_mul(Mul_A, Mul_B);
        Mul_Done = 1'b1;
        done_cyc = cyc;
      end else begin
        mcnt++;
      end
    end
  end

  // ---------------- response monitor ----------------
  always @(posedge Clk) begin
    logic [1:0] ai;
    #1;
    ai = 2'd0;
    if (Ack !== '0) begin
      for (int i = 0; i < N; i++) if (Ack[i]) ai = 2'(i);
      if ($countones(Ack) != 1) bad_oh++;
      obs_q.push_back({ai, RspErr, RspUnf, RspOvf, RspP});
      ack_cyc = cyc;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic apply_reset();
    Req = '0;
    Rst_n = 1'b0;
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    Rst_n = 1'b1;
    exp_q.delete();
    obs_q.delete();
    bad_oh = 0;
  endtask

  task automatic set_ops(input int i, input logic [31:0] a, input logic [31:0] b);
    ReqA[i*32 +: 32] = a;
    ReqB[i*32 +: 32] = b;
  endtask

  // Runs until n Acks, dropping each acked Req unless it is in keep.
  task automatic run_acks(input int n, input int budget, input logic [N-1:0] keep);
    int got;
    got = 0;
    for (int c = 0; c < budget && got < n; c++) begin
      @(posedge Clk); #1;
      if (Ack !== '0) begin
        got++;
        Req = Req & ~(Ack & ~keep);
      end
    end
    #1;
    vectors++;
    if (got != n) begin
      miscompares++;
      $display("FAIL ack_count got=%0d want=%0d", got, n);
    end
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < 60 && !ok; c++) begin
      @(posedge Clk); #1;
      if (Dbg_State == IDLE && !Busy) ok = 1'b1;
    end
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL idle_return got=state%0d want=IDLE", Dbg_State);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    Rst_n = 1'b0;
    Req = '1;
    for (int i = 0; i < N; i++) set_ops(i, rand_op(), rand_op());
    repeat (2) @(posedge Clk);
    #1;
    vectors++; if (Ack !== '0) begin miscompares++; $display("FAIL reset_ack got=%h want=0", Ack); end
    vectors++; if (Busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got=%b want=0", Busy); end
    vectors++; if (Mul_St !== 1'b0) begin miscompares++; $display("FAIL reset_mul_st got=%b want=0", Mul_St); end
    vectors++; if (Mul_A !== 32'd0 || Mul_B !== 32'd0) begin miscompares++; $display("FAIL reset_ops got=%h/%h want=0/0", Mul_A, Mul_B); end
    vectors++; if ({RspP, RspOvf, RspUnf, RspErr} !== 35'd0) begin miscompares++; $display("FAIL reset_rsp got=%h want=0", {RspP, RspOvf, RspUnf, RspErr}); end
    vectors++; if (Dbg_State !== IDLE) begin miscompares++; $display("FAIL reset_state got=%0d want=0", Dbg_State); end
    apply_reset();
  endtask

  task automatic test_single();
    logic [W-1:0] o;
    apply_reset();
    mul_lat = 2;
    set_ops(0, 32'h4000_0000, 32'h4040_0000);
    @(posedge Clk); #1;
    Req = 4'b0001;
    @(posedge Clk); #1;
    vectors++; if (Mul_St !== 1'b1) begin miscompares++; $display("FAIL single_st_latency got=%b want=1", Mul_St); end
    vectors++; if (Mul_A !== 32'h4000_0000 || Mul_B !== 32'h4040_0000) begin miscompares++; $display("FAIL single_ops got=%h/%h want=40000000/40400000", Mul_A, Mul_B); end
    vectors++; if (Busy !== 1'b1) begin miscompares++; $display("FAIL single_busy got=%b want=1", Busy); end
    run_acks(1, 40, '0);
    vectors++; if (Ack !== 4'b0001) begin miscompares++; $display("FAIL single_ack got=%b want=0001", Ack); end
    vectors++; if (RspP !== 32'h40C0_0000) begin miscompares++; $display("FAIL single_prod got=%h want=40c00000", RspP); end
    vectors++; if ({RspOvf, RspUnf, RspErr} !== 3'b000) begin miscompares++; $display("FAIL single_flags got=%b want=000", {RspOvf, RspUnf, RspErr}); end
    vectors++; if (ack_cyc != done_cyc + 1) begin miscompares++; $display("FAIL single_ack_latency got=%0d want=%0d", ack_cyc, done_cyc + 1); end
    @(posedge Clk); #1;
    vectors++; if (Ack !== '0) begin miscompares++; $display("FAIL single_ack_pulse got=%b want=0000", Ack); end
    vectors++; if (RspP !== 32'h40C0_0000) begin miscompares++; $display("FAIL single_rsp_hold got=%h want=40c00000", RspP); end
    wait_idle();
    o = (obs_q.size() > 0) ? obs_q.pop_front() : '1;
    vectors++; if (o[36:35] !== 2'd0) begin miscompares++; $display("FAIL single_grant got=%0d want=0", o[36:35]); end
    obs_q.delete();
  endtask

  task automatic test_drop_mid();
    logic [W-1:0] e, o;
    mul_lat = 3;
    set_ops(1, rand_op(), rand_op());
    e = mk_exp(1, fp_mul(ReqA[63:32], ReqB[63:32]));
    Req = 4'b0010;
    @(posedge Clk); #1;
    Req = 4'b0000;
    run_acks(1, 40, '0);
    o = (obs_q.size() > 0) ? obs_q.pop_front() : '1;
    vectors++; if (o !== e) begin miscompares++; $display("FAIL drop_mid_rsp got=%h want=%h", o, e); end
    wait_idle();
    obs_q.delete();
  endtask

  task automatic test_all_four();
    int busy_low, got;
    logic [W-1:0] e, o;
    apply_reset();
    mul_lat = 1;
    for (int i = 0; i < N; i++) begin
      set_ops(i, rand_op(), rand_op());
      exp_q.push_back(mk_exp(i, fp_mul(ReqA[i*32 +: 32], ReqB[i*32 +: 32])));
    end
    Req = 4'b1111;
    busy_low = 0; got = 0;
    for (int c = 0; c < 200 && got < 4; c++) begin
      @(posedge Clk); #1;
      if (!Busy) busy_low++;
      if (Ack !== '0) begin got++; Req = Req & ~Ack; end
    end
    #1;
    vectors++; if (got != 4) begin miscompares++; $display("FAIL all4_count got=%0d want=4", got); end
    vectors++; if (busy_low != 0) begin miscompares++; $display("FAIL all4_busy_gaps got=%0d want=0", busy_low); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : '1;
      vectors++; if (o !== e) begin miscompares++; $display("FAIL all4_rsp got=%h want=%h", o, e); end
    end
    vectors++; if (bad_oh != 0) begin miscompares++; $display("FAIL all4_onehot got=%0d want=0", bad_oh); end
    wait_idle();
  endtask

  task automatic test_ovf_unf();
    logic [W-1:0] o;
    mul_lat = 0;
    set_ops(0, 32'h7F00_0000, 32'h7F00_0000);
    Req = 4'b0001;
    run_acks(1, 40, '0);
    o = (obs_q.size() > 0) ? obs_q.pop_front() : '0;
    vectors++; if (o[34:32] !== 3'b001) begin miscompares++; $display("FAIL ovf_flags got=%b want=001", o[34:32]); end
    wait_idle();
    set_ops(0, 32'h0080_0000, 32'h0080_0000);
    Req = 4'b0001;
    run_acks(1, 40, '0);
    o = (obs_q.size() > 0) ? obs_q.pop_front() : '0;
    vectors++; if (o[34:32] !== 3'b010) begin miscompares++; $display("FAIL unf_flags got=%b want=010", o[34:32]); end
    wait_idle();
  endtask

  task automatic test_timeout();
    int st_cnt;
    logic [W-1:0] e, o;
    apply_reset();
    mul_hang = 1'b1;
    set_ops(1, rand_op(), rand_op());
    Req = 4'b0010;
    st_cnt = 0;
    for (int c = 0; c < 60; c++) begin
      @(posedge Clk); #1;
      if (Mul_St) st_cnt++;
      if (Ack !== '0) begin Req = Req & ~Ack; break; end
    end
    #1;
    vectors++; if (st_cnt != TMO) begin miscompares++; $display("FAIL tmo_issue_cycles got=%0d want=%0d", st_cnt, TMO); end
    o = (obs_q.size() > 0) ? obs_q.pop_front() : '0;
    vectors++; if (o !== {2'd1, 3'b100, 32'd0}) begin miscompares++; $display("FAIL tmo_rsp got=%h want=%h", o, {2'd1, 3'b100, 32'd0}); end
    mul_hang = 1'b0;
    wait_idle();
    for (int i = 0; i < 2; i++) set_ops(i, rand_op(), rand_op());
    begin
      int mptr;
      int j;
      logic [N-1:0] pend;
      pend = 4'b0011; mptr = 2;
      while (pend != 0) begin
        j = rr_next(pend, mptr);
        exp_q.push_back(mk_exp(j, fp_mul(ReqA[j*32 +: 32], ReqB[j*32 +: 32])));
        pend[j] = 1'b0; mptr = (j + 1) % N;
      end
    end
    Req = 4'b0011;
    run_acks(2, 80, '0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : '1;
      vectors++; if (o !== e) begin miscompares++; $display("FAIL tmo_ptr_order got=%h want=%h", o, e); end
    end
    wait_idle();
  endtask

  task automatic test_reset_mid_issue();
    logic [W-1:0] e, o;
    apply_reset();
    mul_lat = 0;
    set_ops(0, rand_op(), rand_op());
    Req = 4'b0001;
    run_acks(1, 40, '0);
    wait_idle();
    obs_q.delete();
    mul_hang = 1'b1;
    for (int i = 1; i < 3; i++) set_ops(i, rand_op(), rand_op());
    Req = 4'b0110;
    repeat (4) @(posedge Clk);
    #3;
    Rst_n = 1'b0;
    #1;
    vectors++; if (Mul_St !== 1'b0) begin miscompares++; $display("FAIL rst_mid_mul_st got=%b want=0", Mul_St); end
    vectors++; if (Dbg_State !== IDLE || Busy !== 1'b0) begin miscompares++; $display("FAIL rst_mid_state got=%0d/%b want=0/0", Dbg_State, Busy); end
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    Rst_n = 1'b1;
    vectors++; if (obs_q.size() != 0) begin miscompares++; $display("FAIL rst_mid_no_ack got=%0d want=0", obs_q.size()); end
    mul_hang = 1'b0;
    set_ops(0, rand_op(), rand_op());
    for (int i = 0; i < 3; i++) exp_q.push_back(mk_exp(i, fp_mul(ReqA[i*32 +: 32], ReqB[i*32 +: 32])));
    Req = 4'b0111;
    run_acks(3, 120, '0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : '1;
      vectors++; if (o !== e) begin miscompares++; $display("FAIL rst_mid_regrant got=%h want=%h", o, e); end
    end
    wait_idle();
  endtask

  task automatic test_alternate();
    logic [W-1:0] e, o;
    int order [4];
    apply_reset();
    mul_lat = 1;
    order = '{0, 2, 0, 2};
    set_ops(0, rand_op(), rand_op());
    set_ops(2, rand_op(), rand_op());
    for (int k = 0; k < 4; k++)
      exp_q.push_back(mk_exp(order[k], fp_mul(ReqA[order[k]*32 +: 32], ReqB[order[k]*32 +: 32])));
    Req = 4'b0101;
    run_acks(4, 160, 4'b0101);
    Req = '0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : '1;
      vectors++; if (o !== e) begin miscompares++; $display("FAIL alternate_rsp got=%h want=%h", o, e); end
    end
    wait_idle();
    obs_q.delete();
  endtask

  task automatic test_random();
    logic [W-1:0] e, o;
    logic [N-1:0] mask, pend;
    int mptr, j;
    apply_reset();
    mptr = 0;
    for (int r = 0; r < 10; r++) begin
      mask = 4'($urandom_range(1, 15));
      mul_lat = $urandom_range(0, 4);
      for (int i = 0; i < N; i++) set_ops(i, rand_op(), rand_op());
      pend = mask;
      while (pend != 0) begin
        j = rr_next(pend, mptr);
        exp_q.push_back(mk_exp(j, fp_mul(ReqA[j*32 +: 32], ReqB[j*32 +: 32])));
        pend[j] = 1'b0; mptr = (j + 1) % N;
      end
      Req = mask;
      run_acks($countones(mask), 200, '0);
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        o = (obs_q.size() > 0) ? obs_q.pop_front() : '1;
        vectors++; if (o !== e) begin miscompares++; $display("FAIL random_rsp round=%0d got=%h want=%h", r, o, e); end
      end
      wait_idle();
      obs_q.delete();
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_drop_mid();
    test_all_four();
    test_ovf_unf();
    test_timeout();
    test_reset_mid_issue();
    test_alternate();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
